// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants shared with the sync generator, and the
// receiver's lock-state encoding.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned H_SYNC      = 96;
    localparam int unsigned H_BACK      = 48;
    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned V_ACTIVE    = 480;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_BACK      = 33;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        StSearch,
        StLine,
        StVerify,
        StLocked
    } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Previous-tick sync samples and the resulting edge strobes. Strobes are
// combinational against the current inputs; the caller qualifies them with pix_en.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic h_sync_in,
    input  logic v_sync_in,
    output logic hrise,
    output logic hfall,
    output logic vrise
);

    logic h_prev_q, h_prev_d;
    logic v_prev_q, v_prev_d;

    always_comb begin
        h_prev_d = h_prev_q;
        v_prev_d = v_prev_q;
        if (pix_en) begin
            h_prev_d = h_sync_in;
            v_prev_d = v_sync_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_prev_q <= 1'b0;
            v_prev_q <= 1'b0;
        end else begin
            h_prev_q <= h_prev_d;
            v_prev_q <= v_prev_d;
        end
    end

    assign hrise = ~h_prev_q & h_sync_in;
    assign hfall = h_prev_q & ~h_sync_in;
    // A frame edge only counts when it lines up with a line edge.
    assign vrise = hrise & ~v_prev_q & v_sync_in;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA timing sink: rebuilds pixel coordinates from h/v sync, checks the raster
// against the expected timing, locks onto it and strobes out active pixels.
module vga_sync_receiver #(
    parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
    parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
    parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int unsigned LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic        pixel_valid,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [11:0] pixel_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_error,
    output logic [7:0]  err_count
);

    import vga_timing_pkg::*;

    localparam logic [9:0] CNT_MAX      = 10'h3FF;
    localparam logic [9:0] HC_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] HC_SYNC_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] VC_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] VC_SYNC_LAST = 10'(V_SYNC - 1);
    localparam logic [9:0] X_START      = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] X_END        = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] Y_START      = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] Y_END        = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [3:0] LOCK_TARGET  = 4'(LOCK_FRAMES);

    logic hrise, hfall, vrise;

    rx_state_e   state_q, state_d;
    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic [2:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  frame_cnt_inc;
    logic        pixel_valid_q, pixel_valid_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic [11:0] pixel_rgb_q, pixel_rgb_d;
    logic        frame_start_q, frame_start_d;
    logic        timing_error_q, timing_error_d;
    logic [7:0]  err_count_q, err_count_d;

    logic e_len, e_hsync, e_long, e_lines, e_vsync;
    logic err;

    sync_edge_detect u_edge (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .h_sync_in (h_sync_in),
        .v_sync_in (v_sync_in),
        .hrise     (hrise),
        .hfall     (hfall),
        .vrise     (vrise)
    );

    // Checks see hc_q/vc_q as left by the previous tick, so a clean line ends
    // with hc_q == H_TOTAL-1 on the tick that carries the next h_sync rise.
    assign e_len   = hrise && (hc_q != HC_LAST);
    assign e_hsync = hfall && (hc_q != HC_SYNC_LAST);
    assign e_long  = !hrise && (hc_q == HC_LAST);
    assign e_lines = vrise && (vc_q != VC_LAST) && (state_q != StLine);
    assign e_vsync = hrise && !v_sync_in && (vc_q < VC_SYNC_LAST);
    assign err     = pix_en && (state_q != StSearch)
                     && (e_len || e_hsync || e_long || e_lines || e_vsync);

    assign frame_cnt_inc = {1'b0, frame_cnt_q} + 4'd1;

    always_comb begin
        state_d        = state_q;
        hc_d           = hc_q;
        vc_d           = vc_q;
        frame_cnt_d    = frame_cnt_q;
        pixel_valid_d  = 1'b0;
        pixel_x_d      = pixel_x_q;
        pixel_y_d      = pixel_y_q;
        pixel_rgb_d    = pixel_rgb_q;
        frame_start_d  = 1'b0;
        timing_error_d = 1'b0;
        err_count_d    = err_count_q;

        if (pix_en) begin
            if (hrise) begin
                hc_d = '0;
                if (vrise) begin
                    vc_d = '0;
                end else if (vc_q != CNT_MAX) begin
                    vc_d = vc_q + 10'd1;
                end
            end else if (hc_q != CNT_MAX) begin
                hc_d = hc_q + 10'd1;
            end

            unique case (state_q)
                StSearch: if (hrise) state_d = StLine;
                StLine: begin
                    if (vrise) begin
                        state_d     = StVerify;
                        frame_cnt_d = '0;
                    end
                end
                StVerify: begin
                    if (vrise) begin
                        frame_cnt_d = frame_cnt_inc[2:0];
                        if (frame_cnt_inc == LOCK_TARGET) state_d = StLocked;
                    end
                end
                StLocked: ;
                default: state_d = StSearch;
            endcase

            if (err) begin
                state_d        = StSearch;
                timing_error_d = 1'b1;
                if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            end

            frame_start_d = vrise && (state_q == StLocked) && !err;

            // Window uses this tick's raster position (hc after update).
            if ((state_q == StLocked) && (hc_d >= X_START) && (hc_d < X_END)
                && (vc_q >= Y_START) && (vc_q < Y_END)) begin
                pixel_valid_d = 1'b1;
                pixel_x_d     = hc_d - X_START;
                pixel_y_d     = vc_q - Y_START;
                pixel_rgb_d   = {red_in, green_in, blue_in};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StSearch;
            hc_q           <= '0;
            vc_q           <= '0;
            frame_cnt_q    <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_x_q      <= '0;
            pixel_y_q      <= '0;
            pixel_rgb_q    <= '0;
            frame_start_q  <= 1'b0;
            timing_error_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            hc_q           <= hc_d;
            vc_q           <= vc_d;
            frame_cnt_q    <= frame_cnt_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_x_q      <= pixel_x_d;
            pixel_y_q      <= pixel_y_d;
            pixel_rgb_q    <= pixel_rgb_d;
            frame_start_q  <= frame_start_d;
            timing_error_q <= timing_error_d;
            err_count_q    <= err_count_d;
        end
    end

    assign pixel_valid  = pixel_valid_q;
    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign pixel_rgb    = pixel_rgb_q;
    assign frame_start  = frame_start_q;
    assign locked       = (state_q == StLocked);
    assign timing_error = timing_error_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled-down raster (16x10 ticks,
// 8x4 active) so that many frames fit in a short run.
module tb_vga_sync_receiver;

    localparam int HA = 8, HSY = 3, HB = 2, HT = 16;
    localparam int VA = 4, VSY = 2, VB = 2, VT = 10;
    localparam int LF = 2;
    localparam int HOFF = HSY + HB, VOFF = VSY + VB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        h_in = 1'b0, v_in = 1'b0;
    logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
    logic        pixel_valid, frame_start, locked, timing_error;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] pixel_rgb;
    logic [7:0]  err_count;

    vga_sync_receiver #(
        .H_ACTIVE (HA), .H_SYNC (HSY), .H_BACK (HB), .H_TOTAL (HT),
        .V_ACTIVE (VA), .V_SYNC (VSY), .V_BACK (VB), .V_TOTAL (VT),
        .LOCK_FRAMES (LF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_en       (pix_en),
        .h_sync_in    (h_in),
        .v_sync_in    (v_in),
        .red_in       (r_in),
        .green_in     (g_in),
        .blue_in      (b_in),
        .pixel_valid  (pixel_valid),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_rgb    (pixel_rgb),
        .frame_start  (frame_start),
        .locked       (locked),
        .timing_error (timing_error),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0, n_fail = 0;
    int n_err = 0, n_fs = 0, n_pix = 0, n_vr = 0;
    int gh = 0, gv = 0, cur_gh = -1000, cur_gv = -1000;
    int alt_line = -1, alt_len = HT, alt_sync = HSY;
    int first_gh = -1, first_gv = -1, first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    int e0, f0, vr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pat(input int x, input int y);
        logic [3:0] c;
        c = x[3:0] ^ y[3:0];
        return {c, c, c};
    endfunction

    // One pixel tick: pix_en high for one clk, then low for one clk; outputs
    // produced by the tick are sampled on the following falling edge.
    task automatic tick(input logic h, input logic v, input logic [11:0] rgb);
        @(negedge clk);
        h_in = h;
        v_in = v;
        {r_in, g_in, b_in} = rgb;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        if (timing_error) n_err++;
        if (frame_start) n_fs++;
        if (pixel_valid) begin
            n_pix++;
            if (n_pix == 1) begin
                first_gh = cur_gh; first_gv = cur_gv;
                first_x = int'(pixel_x); first_y = int'(pixel_y);
            end
            last_x = int'(pixel_x);
            last_y = int'(pixel_y);
            check("pix_x", pixel_x, cur_gh - HOFF);
            check("pix_y", pixel_y, cur_gv - VOFF);
            check("pix_rgb", pixel_rgb, pat(cur_gh - HOFF, cur_gv - VOFF));
        end
    endtask

    task automatic raw_tick(input logic h, input logic v);
        cur_gh = -1000;
        cur_gv = -1000;
        tick(h, v, 12'h0);
    endtask

    task automatic gen_step();
        int len, sy;
        logic [11:0] rgb;
        len = (gv == alt_line) ? alt_len : HT;
        sy  = (gv == alt_line) ? alt_sync : HSY;
        rgb = '0;
        if (gh >= HOFF && gh < HOFF + HA && gv >= VOFF && gv < VOFF + VA)
            rgb = pat(gh - HOFF, gv - VOFF);
        cur_gh = gh;
        cur_gv = gv;
        if (gh == 0 && gv == 0) n_vr++;
        tick(gh < sy, gv < VSY, rgb);
        if (gh >= len - 1) begin
            gh = 0;
            if (gv == alt_line) alt_line = -1;
            gv = (gv + 1) % VT;
        end else begin
            gh++;
        end
    endtask

    task automatic gen_until(input int th, input int tv, input int budget);
        int k;
        k = 0;
        while (!(gh == th && gv == tv) && k < budget) begin
            gen_step();
            k++;
        end
        check("gen_reach", (gh == th && gv == tv), 1);
    endtask

    task automatic relock(input string tag);
        int k, v0;
        k = 0;
        v0 = n_vr;
        while (!locked && k < 2000) begin
            gen_step();
            k++;
        end
        check({tag, "_locked"}, locked, 1);
        check({tag, "_vrises"}, n_vr - v0, LF + 1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", pixel_valid, 0);
        check("rst_x", pixel_x, 0);
        check("rst_y", pixel_y, 0);
        check("rst_rgb", pixel_rgb, 0);
        check("rst_fs", frame_start, 0);
        check("rst_locked", locked, 0);
        check("rst_terr", timing_error, 0);
        check("rst_errcnt", err_count, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) raw_tick(1'b0, 1'b0);

        // Clean stream joined mid-frame: lock on the third v_sync rise
        gh = 0;
        gv = 5;
        relock("initial");

        // One full locked frame
        n_pix = 0;
        f0 = n_fs;
        e0 = n_err;
        repeat (HT * VT) gen_step();
        check("frame_strobes", n_pix, HA * VA);
        check("frame_starts", n_fs - f0, 1);
        check("first_at_h", first_gh, HOFF);
        check("first_at_v", first_gv, VOFF);
        check("first_x", first_x, 0);
        check("first_y", first_y, 0);
        check("last_x", last_x, HA - 1);
        check("last_y", last_y, VA - 1);
        check("clean_errs", n_err - e0, 0);
        check("clean_locked", locked, 1);

        // Line stretched by one tick while locked
        alt_line = 2; alt_len = HT + 1; alt_sync = HSY;
        e0 = n_err;
        gen_until(0, 4, 200);
        check("long_pulses", n_err - e0, 1);
        check("long_errcnt", err_count, 1);
        check("long_locked", locked, 0);
        relock("relock_long");

        // h_sync one tick short while locked
        alt_line = 2; alt_len = HT; alt_sync = HSY - 1;
        e0 = n_err;
        gen_until(0, 3, 200);
        check("hsync_pulses", n_err - e0, 1);
        check("hsync_errcnt", err_count, 2);
        check("hsync_locked", locked, 0);
        relock("relock_hsync");

        // Frame cut short mid-line: bad line length and line count on one tick
        gen_until(10, 8, 400);
        e0 = n_err;
        gh = 0;
        gv = 0;
        gen_step();
        check("cut_pulses", n_err - e0, 1);
        check("cut_errcnt", err_count, 3);
        check("cut_locked", locked, 0);

        // Short line with short h_sync on the same line
        alt_line = 1; alt_len = HT - 1; alt_sync = HSY - 1;
        e0 = n_err;
        gen_until(0, 3, 200);
        check("combo_pulses", n_err - e0, 1);
        check("combo_errcnt", err_count, 4);
        relock("relock_combo");

        // Reset asserted in the middle of an active line
        gen_until(HOFF + 1, 5, 400);
        check("pre_rst_valid", pixel_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", pixel_valid, 0);
        check("mid_rst_x", pixel_x, 0);
        check("mid_rst_y", pixel_y, 0);
        check("mid_rst_rgb", pixel_rgb, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_errcnt", err_count, 0);
        for (int i = 0; i < 6; i++) begin
            gen_step();
            check("in_rst_valid", pixel_valid, 0);
        end
        reset = 1'b0;
        relock("relock_reset");
        check("post_rst_errcnt", err_count, 0);

        // h_sync stuck high: one overlong-line error, then silence
        gen_until(0, 3, 200);
        e0 = n_err;
        repeat (1100) raw_tick(1'b1, 1'b0);
        check("stuck_pulses", n_err - e0, 1);
        check("stuck_errcnt", err_count, 1);
        check("stuck_locked", locked, 0);

        // 300 forced errors: rise to leave SEARCH, then fall too early
        raw_tick(1'b0, 1'b0);
        e0 = n_err;
        for (int i = 0; i < 253; i++) begin
            raw_tick(1'b1, 1'b0);
            raw_tick(1'b0, 1'b0);
        end
        check("sat_errcnt_254", err_count, 254);
        for (int i = 0; i < 47; i++) begin
            raw_tick(1'b1, 1'b0);
            raw_tick(1'b0, 1'b0);
        end
        check("sat_errcnt_255", err_count, 255);
        check("sat_pulses", n_err - e0, 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
